// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential double-dabble binary-to-BCD converter.
// Contents:
//   IDLE_ENC/SHIFT_ENC/DONE_ENC  state encodings, plus the state_t enum built from them
//   BCD_DIGIT_W                  bits per packed BCD digit
//   ADD3_THRESHOLD               digit value at and above which the +3 correction applies
//   clog2()                      width of the shift counter for a given word length
// Optional feature macro used by the files that import this package: BIN2BCD_SIGN_EN.
package bin2bcd_pkg;

  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] SHIFT_ENC = 2'd1;
  localparam logic [1:0] DONE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = IDLE_ENC,
    SHIFT = SHIFT_ENC,
    DONE  = DONE_ENC
  } state_t;

  localparam int BCD_DIGIT_W = 4;

  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESHOLD = 4'd5;

  // Never returns less than 1 so a one-bit word still gets a real counter.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_converter_if.sv
// Handshake/data bundle between a requester and bin2bcd_seq_converter.
// Signals:
//   start       requester -> converter  conversion request
//   Data_Input  requester -> converter  binary operand (two's complement with BIN2BCD_SIGN_EN)
//   busy        converter -> requester  conversion in progress
//   load        converter -> requester  one-cycle strobe, BCD_Output valid
//   BCD_Output  converter -> requester  packed BCD, digit 0 in bits [3:0]
//   sign        converter -> requester  result sign, present only with BIN2BCD_SIGN_EN
// Modports: master (requester side), slave (converter side).
interface bin2bcd_seq_converter_if #(
  parameter int WORD_LENGTH = 8,
  parameter int DIGITS      = 3
);
  import bin2bcd_pkg::*;

  logic                          start;
  logic [WORD_LENGTH-1:0]        Data_Input;
  logic                          busy;
  logic                          load;
  logic [BCD_DIGIT_W*DIGITS-1:0] BCD_Output;
`ifdef BIN2BCD_SIGN_EN
  logic                          sign;
`endif

`ifdef BIN2BCD_SIGN_EN
  modport master (output start, output Data_Input,
                  input busy, input load, input BCD_Output, input sign);
  modport slave  (input start, input Data_Input,
                  output busy, output load, output BCD_Output, output sign);
`else
  modport master (output start, output Data_Input,
                  input busy, input load, input BCD_Output);
  modport slave  (input start, input Data_Input,
                  output busy, output load, output BCD_Output);
`endif

endinterface

// File: rtl/bcd_add3_digit.sv
// One BCD digit's double-dabble correction: values of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
// Ports:
//   digit_in   in  4  digit before correction
//   digit_out  out 4  corrected digit (4-bit wrap, no carry out)
module bcd_add3_digit
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  // Purely combinational; inputs only ever reach 9 so the 4-bit add cannot wrap.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= ADD3_THRESHOLD) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq_converter.sv
// Iterative shift-add-3 binary-to-BCD converter. One operand per accepted start,
// WORD_LENGTH shift cycles, then a single DONE cycle that publishes the result
// and raises the one-cycle load strobe for the downstream holding register.
// Ports:
//   clk    in  single clock, rising edge
//   reset  in  asynchronous, active-high
//   bus    bin2bcd_seq_converter_if.slave (start, Data_Input, busy, load, BCD_Output[, sign])
// Macro BIN2BCD_SIGN_EN: Data_Input is two's complement; its magnitude is converted
// and sign is published alongside BCD_Output.
module bin2bcd_seq_converter
  import bin2bcd_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int DIGITS      = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  bin2bcd_seq_converter_if.slave        bus
);

  localparam int CW     = clog2(WORD_LENGTH);
  localparam int BCD_W  = BCD_DIGIT_W * DIGITS;

  state_t                 state;
  state_t                 next_state;
  logic [CW-1:0]          count;
  logic [WORD_LENGTH-1:0] bin;
  logic [BCD_W-1:0]       acc;
  logic [BCD_W-1:0]       acc_adj;
  logic [WORD_LENGTH-1:0] operand;
`ifdef BIN2BCD_SIGN_EN
  logic                   sign_pending;
`endif

  // Every digit is corrected in parallel before each shift.
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : gen_add3
      bcd_add3_digit u_add3 (
        .digit_in  (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digit_out (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Value loaded into the shift register; the most negative input negates to
  // itself, which read as unsigned is exactly its magnitude.
`ifdef BIN2BCD_SIGN_EN
  assign operand = bus.Data_Input[WORD_LENGTH-1] ? -bus.Data_Input : bus.Data_Input;
`else
  assign operand = bus.Data_Input;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: start only matters in IDLE, so requests during SHIFT or
  // DONE are dropped rather than queued.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = SHIFT;
      SHIFT:   if (count == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs. busy follows the upcoming state so it is
  // high exactly for the SHIFT cycles; BCD_Output only changes in DONE so it
  // never shows a partially converted value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count          <= '0;
      bin            <= '0;
      acc            <= '0;
      bus.busy       <= 1'b0;
      bus.load       <= 1'b0;
      bus.BCD_Output <= '0;
`ifdef BIN2BCD_SIGN_EN
      sign_pending   <= 1'b0;
      bus.sign       <= 1'b0;
`endif
    end else begin
      bus.busy <= (next_state == SHIFT);
      bus.load <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin   <= operand;
            acc   <= '0;
            count <= CW'(WORD_LENGTH - 1);
`ifdef BIN2BCD_SIGN_EN
            sign_pending <= bus.Data_Input[WORD_LENGTH-1];
`endif
          end
        end
        SHIFT: begin
          acc   <= {acc_adj[BCD_W-2:0], bin[WORD_LENGTH-1]};
          bin   <= {bin[WORD_LENGTH-2:0], 1'b0};
          count <= count - 1'b1;
        end
        DONE: begin
          bus.BCD_Output <= acc;
`ifdef BIN2BCD_SIGN_EN
          bus.sign       <= sign_pending;
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq_converter.sv
// Scoreboard bench for bin2bcd_seq_converter: stimulus pushes the hand-computed
// result and the cycle its load strobe is due; a negedge monitor pops and compares.
// Builds with or without BIN2BCD_SIGN_EN; each vector carries both expectations.
module tb_bin2bcd_seq_converter;

  localparam int WL = 8;
  localparam int DG = 3;
`ifdef BIN2BCD_SIGN_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

  typedef struct {
    logic [11:0] bcd;
    logic        sign;
    int          load_cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb_q[$];
  logic [11:0] bcd_held;

  bin2bcd_seq_converter_if #(.WORD_LENGTH(WL), .DIGITS(DG)) bus ();

  bin2bcd_seq_converter #(.WORD_LENGTH(WL), .DIGITS(DG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Issue one start pulse; Data_Input is scrambled right after capture.
  task automatic applyStimulus(input logic [7:0] value, input logic [11:0] exp_u,
                               input logic [11:0] exp_s, input logic exp_sign);
    exp_t item;
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.Data_Input = value;
    item.bcd       = SIGNED_MODE ? exp_s : exp_u;
    item.sign      = SIGNED_MODE ? exp_sign : 1'b0;
    item.load_cyc  = cyc + 1 + WL + 1;
    sb_q.push_back(item);
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.Data_Input = ~value;
  endtask

  task automatic waitIdle();
    repeat (WL + 3) @(posedge clk);
  endtask

  // Monitor: compares each load against the scoreboard head, flags loads
  // that are unexpected or overdue, and checks BCD_Output holds between loads.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.load) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_load", 32'(bus.load), 32'd0);
        end else begin
          exp_t item;
          item = sb_q.pop_front();
          checkOutput("load_cycle", cyc, item.load_cyc);
          checkOutput("bcd", 32'(bus.BCD_Output), 32'(item.bcd));
`ifdef BIN2BCD_SIGN_EN
          checkOutput("sign", 32'(bus.sign), 32'(item.sign));
`endif
          bcd_held = item.bcd;
        end
      end else begin
        checkOutput("bcd_hold", 32'(bus.BCD_Output), 32'(bcd_held));
        if (sb_q.size() > 0 && cyc > sb_q[0].load_cyc) begin
          checkOutput("load_missing", 32'(bus.load), 32'd1);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    int busy_cycles;
    int acc_edge;
    cyc            = 0;
    checks         = 0;
    errors         = 0;
    bcd_held       = '0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.Data_Input = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_load", 32'(bus.load), 32'd0);
    checkOutput("rst_bcd", 32'(bus.BCD_Output), 32'd0);
`ifdef BIN2BCD_SIGN_EN
    checkOutput("rst_sign", 32'(bus.sign), 32'd0);
`endif
    @(posedge clk);
    #2;
    reset = 1'b0;

    // 255 with latency and busy-width check
    applyStimulus(8'd255, 12'h255, 12'h001, 1'b1);
    busy_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cycles++;
    end
    checkOutput("busy_width", busy_cycles, 8);

    // Zero and decimal boundaries
    applyStimulus(8'd0, 12'h000, 12'h000, 1'b0);
    waitIdle();
    applyStimulus(8'd99, 12'h099, 12'h099, 1'b0);
    waitIdle();
    applyStimulus(8'd100, 12'h100, 12'h100, 1'b0);
    waitIdle();

    // start held high across two back-to-back conversions
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.Data_Input = 8'd73;
    acc_edge       = cyc + 1;
    sb_q.push_back('{bcd: 12'h073, sign: 1'b0, load_cyc: acc_edge + WL + 1});
    sb_q.push_back('{bcd: (SIGNED_MODE ? 12'h056 : 12'h200), sign: SIGNED_MODE,
                     load_cyc: acc_edge + 2 * (WL + 2) - 1});
    while (cyc < acc_edge + WL + 1) @(negedge clk);
    bus.Data_Input = 8'd200;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.Data_Input = 8'd0;
    waitIdle();

    // start during SHIFT is ignored
    applyStimulus(8'd42, 12'h042, 12'h042, 1'b0);
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.Data_Input = 8'd17;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    waitIdle();

    // Asynchronous reset mid-SHIFT aborts with no load
    applyStimulus(8'd150, 12'h150, 12'h106, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_load", 32'(bus.load), 32'd0);
    checkOutput("abort_bcd", 32'(bus.BCD_Output), 32'd0);
    sb_q.delete();
    bcd_held = '0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    applyStimulus(8'd150, 12'h150, 12'h106, 1'b1);
    waitIdle();

    // Sign-related boundaries
    applyStimulus(8'h80, 12'h128, 12'h128, 1'b1);
    waitIdle();
    applyStimulus(8'hFF, 12'h255, 12'h001, 1'b1);
    waitIdle();
    applyStimulus(8'd127, 12'h127, 12'h127, 1'b0);
    waitIdle();

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
